// File: rtl/sal_cmd_sched.sv
// sal_cmd_sched: DRAM command scheduler, column-over-row priority with per-class round-robin and tRRD/tCCD/tWTR/tRTW gating.
// Define SAL_CMD_SCHED_FAW_EN to add four-activate-window (tFAW) tracking.
module sal_cmd_sched #(
   parameter int BK_CNT     = 8,
   parameter int ADDR_WIDTH = 14,
   parameter int T_RRD      = 2,
   parameter int T_CCD      = 2,
   parameter int T_WTR      = 3,
   parameter int T_RTW      = 4,
   parameter int T_FAW      = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [BK_CNT-1:0]            req_valid,
   input  logic [2*BK_CNT-1:0]          req_cmd,
   input  logic [BK_CNT*ADDR_WIDTH-1:0] req_addr,
   output logic [BK_CNT-1:0]            req_gnt,
   output logic                         cmd_valid,
   output logic [1:0]                   cmd_type,
   output logic [$clog2(BK_CNT)-1:0]    cmd_ba,
   output logic [ADDR_WIDTH-1:0]        cmd_addr
);
   localparam int BW = $clog2(BK_CNT);
   localparam logic [1:0] ACT = 2'd0, RD = 2'd1, WR = 2'd2, PRE = 2'd3;
   logic [3:0] rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
   logic [BW-1:0] col_ptr, row_ptr, col_idx, row_idx, gnt_idx;
   logic [BK_CNT-1:0] col_elig, row_elig;
   logic col_hit, row_hit, accept, faw_ok, ok_act, ok_rd, ok_wr, is_act, is_rd, is_wr;
   logic [1:0] gnt_cmd;
   function automatic logic [3:0] tick(input logic [3:0] c, input logic ld, input int t);
      return ld ? 4'(t - 1) : (c != 4'd0 ? c - 4'd1 : c);
   endfunction
   function automatic logic [BW-1:0] nxt(input logic [BW-1:0] p);
      return (p == BW'(BK_CNT - 1)) ? '0 : p + 1'b1;
   endfunction
   assign ok_act = (rrd_cnt == 4'd0) && faw_ok;
   assign ok_rd  = (ccd_cnt == 4'd0) && (wtr_cnt == 4'd0);
   assign ok_wr  = (ccd_cnt == 4'd0) && (rtw_cnt == 4'd0);
   always_comb begin
      col_elig = '0;
      row_elig = '0;
      for (int i = 0; i < BK_CNT; i++) begin
         col_elig[i] = req_valid[i] && ((req_cmd[2*i +: 2] == RD && ok_rd) || (req_cmd[2*i +: 2] == WR && ok_wr));
         row_elig[i] = req_valid[i] && ((req_cmd[2*i +: 2] == ACT && ok_act) || req_cmd[2*i +: 2] == PRE);
      end
   end
   // descending scan so the last hit is the first eligible index at or after the pointer
   always_comb begin
      int idx;
      idx = 0;
      col_hit = 1'b0;
      row_hit = 1'b0;
      col_idx = '0;
      row_idx = '0;
      for (int k = BK_CNT - 1; k >= 0; k--) begin
         idx = (int'(col_ptr) + k) % BK_CNT;
         if (col_elig[idx]) begin
            col_hit = 1'b1;
            col_idx = BW'(idx);
         end
         idx = (int'(row_ptr) + k) % BK_CNT;
         if (row_elig[idx]) begin
            row_hit = 1'b1;
            row_idx = BW'(idx);
         end
      end
   end
   assign accept  = rst_n && (col_hit || row_hit);
   assign gnt_idx = col_hit ? col_idx : row_idx;
   assign gnt_cmd = req_cmd[{gnt_idx, 1'b0} +: 2];
   assign req_gnt = accept ? (BK_CNT'(1) << gnt_idx) : '0;
   assign is_act  = accept && gnt_cmd == ACT;
   assign is_rd   = accept && gnt_cmd == RD;
   assign is_wr   = accept && gnt_cmd == WR;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rrd_cnt   <= '0;
         ccd_cnt   <= '0;
         wtr_cnt   <= '0;
         rtw_cnt   <= '0;
         col_ptr   <= '0;
         row_ptr   <= '0;
         cmd_valid <= 1'b0;
         cmd_type  <= '0;
         cmd_ba    <= '0;
         cmd_addr  <= '0;
      end else begin
         rrd_cnt   <= tick(rrd_cnt, is_act, T_RRD);
         ccd_cnt   <= tick(ccd_cnt, is_rd || is_wr, T_CCD);
         wtr_cnt   <= tick(wtr_cnt, is_wr, T_WTR);
         rtw_cnt   <= tick(rtw_cnt, is_rd, T_RTW);
         cmd_valid <= accept;
         if (accept && col_hit) col_ptr <= nxt(col_idx);
         if (accept && !col_hit) row_ptr <= nxt(row_idx);
         if (accept) begin
            cmd_type <= gnt_cmd;
            cmd_ba   <= gnt_idx;
            cmd_addr <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end
`ifdef SAL_CMD_SCHED_FAW_EN
   logic [3:0] faw_cnt [4];
   logic [1:0] faw_sel;
   always_comb begin
      faw_ok  = 1'b0;
      faw_sel = '0;
      for (int j = 3; j >= 0; j--) begin
         if (faw_cnt[j] == 4'd0) begin
            faw_ok  = 1'b1;
            faw_sel = 2'(j);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < 4; j++) faw_cnt[j] <= '0;
      end else begin
         for (int j = 0; j < 4; j++) faw_cnt[j] <= tick(faw_cnt[j], is_act && faw_sel == 2'(j), T_FAW);
      end
   end
`else
   assign faw_ok = 1'b1;
`endif
endmodule
